// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

  localparam int unsigned DEFAULT_INST_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_PC_STEP         = 1;
  localparam int unsigned DEFAULT_RAS_DEPTH       = 4;

  typedef enum logic [2:0] {
    PC_SRC_HOLD,
    PC_SRC_SEQ,
    PC_SRC_BR,
    PC_SRC_JMP,
    PC_SRC_CALL,
    PC_SRC_RET
  } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the fetch control logic and the PC unit.
interface pc_unit_if #(
  parameter int unsigned W = 16
) ();

  logic         stall;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic         jump;
  logic         call;
  logic [W-1:0] jump_target;
  logic         ret;
  logic [W-1:0] pc_out;
  logic [W-1:0] pc_next;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_overflow;
  logic         ras_underflow;

  modport master (
    output stall, branch_taken, branch_target, jump, call, jump_target, ret,
    input  pc_out, pc_next, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, call, jump_target, ret,
    output pc_out, pc_next, ras_empty, ras_full, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, underflow_q;
  logic            push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign rdata   = mem_q[top_q];
  assign push_en = push & ~pop;
  assign pop_en  = pop & ~empty;

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    if (pop_en) begin
      top_d   = top_q - PtrW'(1);
      count_d = count_q - CntW'(1);
    end else if (push_en) begin
      top_d = top_q + PtrW'(1);
      if (!full) count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      top_q       <= top_d;
      count_q     <= count_d;
      overflow_q  <= push_en & full;
      underflow_q <= pop & empty;
    end
  end

  // Storage is not reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[top_d] <= wdata;
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: prioritised next-PC select, stall hold and call/return stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned INST_ADDR_WIDTH = DEFAULT_INST_ADDR_WIDTH,
  parameter int unsigned PC_STEP         = DEFAULT_PC_STEP,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned RAS_DEPTH       = DEFAULT_RAS_DEPTH
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);

  localparam int unsigned W = INST_ADDR_WIDTH;

  pc_src_e      src;
  logic [W-1:0] pc_q, pc_d, pc_seq, ras_rdata;
  logic         ras_push, ras_pop, ras_empty, ras_full;

  assign pc_seq = pc_q + W'(PC_STEP);

  always_comb begin
    src      = PC_SRC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (bus.stall) begin
      src = PC_SRC_HOLD;
    end else if (bus.ret) begin
      // A ret on an empty stack still reaches the RAS so it can flag underflow.
      ras_pop = 1'b1;
      src     = ras_empty ? PC_SRC_SEQ : PC_SRC_RET;
    end else if (bus.call) begin
      ras_push = 1'b1;
      src      = PC_SRC_CALL;
    end else if (bus.jump) begin
      src = PC_SRC_JMP;
    end else if (bus.branch_taken) begin
      src = PC_SRC_BR;
    end
  end

  always_comb begin
    pc_d = pc_seq;
    unique case (src)
      PC_SRC_HOLD: pc_d = pc_q;
      PC_SRC_SEQ:  pc_d = pc_seq;
      PC_SRC_BR:   pc_d = bus.branch_target;
      PC_SRC_JMP:  pc_d = bus.jump_target;
      PC_SRC_CALL: pc_d = bus.jump_target;
      PC_SRC_RET:  pc_d = ras_rdata;
      default:     pc_d = pc_seq;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_VECTOR;
    else      pc_q <= pc_d;
  end

  ras_stack #(
    .W     (W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .wdata     (pc_seq),
    .rdata     (ras_rdata),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (bus.ras_overflow),
    .underflow (bus.ras_underflow)
  );

  assign bus.pc_out    = pc_q;
  assign bus.pc_next   = pc_d;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expected PCs.
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_unit_if #(.W(16)) bus ();

  pc_unit #(
    .INST_ADDR_WIDTH (16),
    .PC_STEP         (1),
    .RESET_VECTOR    (16'h0000),
    .RAS_DEPTH       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.call          = 1'b0;
    bus.jump_target   = '0;
    bus.ret           = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [15:0] tgt);
    idle(); bus.jump = 1'b1; bus.jump_target = tgt;
    cyc(); idle();
  endtask

  task automatic do_call(input logic [15:0] tgt);
    idle(); bus.call = 1'b1; bus.jump_target = tgt;
    cyc(); idle();
  endtask

  task automatic do_ret();
    idle(); bus.ret = 1'b1;
    cyc(); idle();
  endtask

  initial begin
    idle();
    #2;
    check_eq("rst_pc", 32'(bus.pc_out), 32'h0);
    check_eq("rst_empty", 32'(bus.ras_empty), 32'h1);
    check_eq("rst_full", 32'(bus.ras_full), 32'h0);
    check_eq("rst_ovf", 32'(bus.ras_overflow), 32'h0);
    check_eq("rst_unf", 32'(bus.ras_underflow), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    cyc();
    check_eq("first_edge_pc", 32'(bus.pc_out), 32'h1);

    // Sequential + stall
    do_jump(16'd10);
    check_eq("jump10", 32'(bus.pc_out), 32'd10);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("stall_hold", 32'(bus.pc_out), 32'd10);
    end
    check_eq("stall_next", 32'(bus.pc_next), 32'd10);
    idle(); cyc();
    check_eq("seq11", 32'(bus.pc_out), 32'd11);
    cyc();
    check_eq("seq12", 32'(bus.pc_out), 32'd12);

    // Priority: jump beats branch; stall beats ret
    do_jump(16'd5);
    bus.branch_taken = 1'b1; bus.branch_target = 16'd40;
    bus.jump = 1'b1; bus.jump_target = 16'd80;
    #1 check_eq("prio_next", 32'(bus.pc_next), 32'd80);
    cyc(); idle();
    check_eq("prio_pc", 32'(bus.pc_out), 32'd80);
    do_call(16'd200);
    check_eq("call200", 32'(bus.pc_out), 32'd200);
    bus.stall = 1'b1; bus.ret = 1'b1;
    cyc(); idle();
    check_eq("stall_ret_pc", 32'(bus.pc_out), 32'd200);
    check_eq("stall_ret_nonempty", 32'(bus.ras_empty), 32'h0);
    do_ret();
    check_eq("ret81", 32'(bus.pc_out), 32'd81);
    check_eq("ret81_empty", 32'(bus.ras_empty), 32'h1);

    // Call / ret
    do_jump(16'd20);
    do_call(16'd100);
    check_eq("call100", 32'(bus.pc_out), 32'd100);
    do_ret();
    check_eq("ret21", 32'(bus.pc_out), 32'd21);
    do_jump(16'd30);
    do_call(16'd300);
    do_call(16'd400);
    do_call(16'd500);
    check_eq("nest_pc", 32'(bus.pc_out), 32'd500);
    do_ret();
    check_eq("nest_ret1", 32'(bus.pc_out), 32'd401);
    do_ret();
    check_eq("nest_ret2", 32'(bus.pc_out), 32'd301);
    do_ret();
    check_eq("nest_ret3", 32'(bus.pc_out), 32'd31);
    check_eq("nest_empty", 32'(bus.ras_empty), 32'h1);
    do_call(16'd600);
    bus.call = 1'b1; bus.ret = 1'b1; bus.jump_target = 16'd700;
    cyc(); idle();
    check_eq("callret_pc", 32'(bus.pc_out), 32'd32);
    check_eq("callret_empty", 32'(bus.ras_empty), 32'h1);

    // RAS bounds
    do_jump(16'd1000);
    do_call(16'd2000);
    do_call(16'd3000);
    do_call(16'd4000);
    do_call(16'd5000);
    check_eq("full4", 32'(bus.ras_full), 32'h1);
    check_eq("no_ovf4", 32'(bus.ras_overflow), 32'h0);
    do_call(16'd6000);
    check_eq("ovf_pulse", 32'(bus.ras_overflow), 32'h1);
    check_eq("full5", 32'(bus.ras_full), 32'h1);
    check_eq("ovf_pc", 32'(bus.pc_out), 32'd6000);
    do_ret();
    check_eq("ovf_ret1", 32'(bus.pc_out), 32'd5001);
    check_eq("ovf_cleared", 32'(bus.ras_overflow), 32'h0);
    do_ret();
    check_eq("ovf_ret2", 32'(bus.pc_out), 32'd4001);
    do_ret();
    check_eq("ovf_ret3", 32'(bus.pc_out), 32'd3001);
    do_ret();
    check_eq("ovf_ret4", 32'(bus.pc_out), 32'd2001);
    check_eq("ovf_empty", 32'(bus.ras_empty), 32'h1);
    do_ret();
    check_eq("unf_pc", 32'(bus.pc_out), 32'd2002);
    check_eq("unf_pulse", 32'(bus.ras_underflow), 32'h1);
    cyc();
    check_eq("unf_cleared", 32'(bus.ras_underflow), 32'h0);
    check_eq("unf_seq", 32'(bus.pc_out), 32'd2003);

    // Address wrap
    do_jump(16'hFFFF);
    cyc();
    check_eq("wrap_seq", 32'(bus.pc_out), 32'h0000);
    do_jump(16'hFFFF);
    do_call(16'h1234);
    check_eq("wrap_call", 32'(bus.pc_out), 32'h1234);
    do_ret();
    check_eq("wrap_ret", 32'(bus.pc_out), 32'h0000);

    // Asynchronous reset with three live RAS entries and a call pending
    do_jump(16'd50);
    do_call(16'd60);
    do_call(16'd70);
    do_call(16'd80);
    bus.call = 1'b1; bus.jump_target = 16'd90;
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check_eq("mid_rst_pc", 32'(bus.pc_out), 32'h0);
    check_eq("mid_rst_empty", 32'(bus.ras_empty), 32'h1);
    idle();
    @(posedge clk); #1 rst = 1'b1;
    check_eq("rel_empty", 32'(bus.ras_empty), 32'h1);
    check_eq("rel_pc", 32'(bus.pc_out), 32'h0);
    cyc();
    check_eq("rel_first_edge", 32'(bus.pc_out), 32'h1);
    do_ret();
    check_eq("rel_ret_unf", 32'(bus.ras_underflow), 32'h1);
    check_eq("rel_ret_pc", 32'(bus.pc_out), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
